// File: rtl/trace_pkg.sv
// Shared types for the commit tracker: per-stage instruction slot and memory-access record.
package trace_pkg;

    localparam int TRACE_W = 16;

    typedef struct packed {
        logic               valid;
        logic [TRACE_W-1:0] pc;
        logic [TRACE_W-1:0] inst;
    } slot_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [TRACE_W-1:0] addr;
        logic [TRACE_W-1:0] data;
    } mem_rec_t;

    localparam slot_t    BUBBLE_SLOT  = '0;
    localparam mem_rec_t MEM_REC_NONE = '0;

endpackage

// File: rtl/trace_slot.sv
// One pipeline metadata slot: clear-to-bubble beats load, otherwise the slot holds.
module trace_slot
    import trace_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  clear_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t slot_q;
    slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = BUBBLE_SLOT;
        end else if (load_i) begin
            slot_d = slot_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= BUBBLE_SLOT;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/commit_tracker.sv
// Shadows the 5-stage pipeline with {valid, pc, inst} slots and emits one registered
// commit record per retired instruction, plus retired/cycle counters and a sticky halt.
module commit_tracker
    import trace_pkg::*;
#(
    parameter int WIDTH = TRACE_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fd_valid,
    input  logic [WIDTH-1:0] fd_pc,
    input  logic [WIDTH-1:0] fd_inst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_reg_write,
    input  logic [2:0]       wb_write_reg,
    input  logic [WIDTH-1:0] wb_write_data,
    input  logic             wb_halt,
    output logic             commit_valid,
    output logic [WIDTH-1:0] commit_pc,
    output logic [WIDTH-1:0] commit_inst,
    output logic             commit_reg_write,
    output logic [2:0]       commit_wreg,
    output logic [WIDTH-1:0] commit_wdata,
    output logic             commit_mem_read,
    output logic             commit_mem_write,
    output logic [WIDTH-1:0] commit_mem_addr,
    output logic [WIDTH-1:0] commit_mem_data,
    output logic             commit_halt,
    output logic             commit_err,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int N_SLOTS = 3;  // D, X, M

    slot_t              slot_in  [N_SLOTS];
    slot_t              slot_out [N_SLOTS];
    logic [N_SLOTS-1:0] slot_load;
    logic [N_SLOTS-1:0] slot_clear;

    // Flush outranks stall: D/X bubble while M still advances from X.
    assign slot_in[0]    = '{valid: fd_valid, pc: fd_pc, inst: fd_inst};
    assign slot_in[1]    = slot_out[0];
    assign slot_in[2]    = slot_out[1];
    assign slot_load[0]  = ~stall;
    assign slot_load[1]  = ~stall;
    assign slot_load[2]  = 1'b1;
    assign slot_clear[0] = flush;
    assign slot_clear[1] = flush;
    assign slot_clear[2] = stall & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            trace_slot u_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (slot_load[gi]),
                .clear_i (slot_clear[gi]),
                .slot_i  (slot_in[gi]),
                .slot_o  (slot_out[gi])
            );
        end
    endgenerate

    slot_t             w_q,        w_d;
    mem_rec_t          w_mem_q,    w_mem_d;
    slot_t             cslot_q,    cslot_d;
    mem_rec_t          cmem_q,     cmem_d;
    logic              creg_wr_q,  creg_wr_d;
    logic [2:0]        cwreg_q,    cwreg_d;
    logic [WIDTH-1:0]  cwdata_q,   cwdata_d;
    logic              halt_q,     halt_d;
    logic              err_q,      err_d;
    logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0]  cyc_cnt_q,  cyc_cnt_d;
    logic              commit_fire;

    assign commit_fire = w_q.valid & ~halt_q;

    always_comb begin
        w_d        = slot_out[2];
        w_mem_d    = '{rd: mem_read, wr: mem_write, addr: mem_addr, data: mem_data};
        cslot_d    = cslot_q;
        cslot_d.valid = commit_fire;
        cmem_d     = cmem_q;
        creg_wr_d  = creg_wr_q;
        cwreg_d    = cwreg_q;
        cwdata_d   = cwdata_q;
        if (commit_fire) begin
            cslot_d.pc   = w_q.pc;
            cslot_d.inst = w_q.inst;
            cmem_d       = w_mem_q;
            creg_wr_d    = wb_reg_write;
            cwreg_d      = wb_write_reg;
            cwdata_d     = wb_write_data;
        end
        halt_d     = halt_q | (commit_fire & wb_halt);
        inst_cnt_d = inst_cnt_q + CNT_W'(commit_fire);
        cyc_cnt_d  = halt_q ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
        // A write request with nothing in W points at a pipeline/tracker desync.
        err_d      = ~w_q.valid & (wb_reg_write | w_mem_q.wr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q        <= BUBBLE_SLOT;
            w_mem_q    <= MEM_REC_NONE;
            cslot_q    <= BUBBLE_SLOT;
            cmem_q     <= MEM_REC_NONE;
            creg_wr_q  <= 1'b0;
            cwreg_q    <= '0;
            cwdata_q   <= '0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
            inst_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            w_q        <= w_d;
            w_mem_q    <= w_mem_d;
            cslot_q    <= cslot_d;
            cmem_q     <= cmem_d;
            creg_wr_q  <= creg_wr_d;
            cwreg_q    <= cwreg_d;
            cwdata_q   <= cwdata_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
            inst_cnt_q <= inst_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign commit_valid     = cslot_q.valid;
    assign commit_pc        = cslot_q.pc;
    assign commit_inst      = cslot_q.inst;
    assign commit_reg_write = creg_wr_q;
    assign commit_wreg      = cwreg_q;
    assign commit_wdata     = cwdata_q;
    assign commit_mem_read  = cmem_q.rd;
    assign commit_mem_write = cmem_q.wr;
    assign commit_mem_addr  = cmem_q.addr;
    assign commit_mem_data  = cmem_q.data;
    assign commit_halt      = halt_q;
    assign commit_err       = err_q;
    assign inst_count       = inst_cnt_q;
    assign cycle_count      = cyc_cnt_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker: pipeline timing, stall, flush, halt, error pulse, reset.
module tb_commit_tracker;

    logic        clk;
    logic        rst;
    logic        fd_valid;
    logic [15:0] fd_pc;
    logic [15:0] fd_inst;
    logic        stall;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        wb_reg_write;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_write_data;
    logic        wb_halt;
    logic        commit_valid;
    logic [15:0] commit_pc;
    logic [15:0] commit_inst;
    logic        commit_reg_write;
    logic [2:0]  commit_wreg;
    logic [15:0] commit_wdata;
    logic        commit_mem_read;
    logic        commit_mem_write;
    logic [15:0] commit_mem_addr;
    logic [15:0] commit_mem_data;
    logic        commit_halt;
    logic        commit_err;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;

    commit_tracker #(.WIDTH(16), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .fd_valid         (fd_valid),
        .fd_pc            (fd_pc),
        .fd_inst          (fd_inst),
        .stall            (stall),
        .flush            (flush),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .wb_reg_write     (wb_reg_write),
        .wb_write_reg     (wb_write_reg),
        .wb_write_data    (wb_write_data),
        .wb_halt          (wb_halt),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_inst      (commit_inst),
        .commit_reg_write (commit_reg_write),
        .commit_wreg      (commit_wreg),
        .commit_wdata     (commit_wdata),
        .commit_mem_read  (commit_mem_read),
        .commit_mem_write (commit_mem_write),
        .commit_mem_addr  (commit_mem_addr),
        .commit_mem_data  (commit_mem_data),
        .commit_halt      (commit_halt),
        .commit_err       (commit_err),
        .inst_count       (inst_count),
        .cycle_count      (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_fail    = 0;
    logic [31:0] cyc_model = 0;
    logic [31:0] halt_cyc  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst === 1'b1) cyc_model++;
    endtask

    function automatic logic [15:0] inst_of(input logic [15:0] pc);
        return 16'hC000 | pc;
    endfunction

    task automatic fetch(input logic v, input logic [15:0] pc);
        fd_valid = v;
        fd_pc    = pc;
        fd_inst  = inst_of(pc);
        tick();
        $display("t=%0t fetch v=%0d pc=%h -> cv=%0d cpc=%h icnt=%0d ccnt=%0d halt=%0d err=%0d",
                 $time, v, pc, commit_valid, commit_pc, inst_count, cycle_count,
                 commit_halt, commit_err);
    endtask

    initial begin
        rst = 1'b0; fd_valid = 0; fd_pc = 0; fd_inst = 0; stall = 0; flush = 0;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0; wb_halt = 0;

        tick(); tick();
        chk("rst_cv",   commit_valid, 0);
        chk("rst_halt", commit_halt, 0);
        chk("rst_err",  commit_err, 0);
        chk("rst_icnt", inst_count, 0);
        chk("rst_ccnt", cycle_count, 0);
        chk("rst_pc",   commit_pc, 0);

        // 1: four back-to-back fetches retire on cycles 5..8
        rst = 1'b1; cyc_model = 0;
        fetch(1, 16'h0); fetch(1, 16'h2); fetch(1, 16'h4);
        fetch(1, 16'h6);
        chk("t1_no_early", commit_valid, 0);
        wb_reg_write = 1; wb_write_reg = 3'd5; wb_write_data = 16'h1234;
        mem_write = 1; mem_addr = 16'h0040; mem_data = 16'hBEEF;
        fetch(0, 0);
        chk("t1_cv0",    commit_valid, 1);
        chk("t1_pc0",    commit_pc, 16'h0);
        chk("t1_inst0",  commit_inst, 16'hC000);
        chk("t1_regwr",  commit_reg_write, 1);
        chk("t1_wreg",   commit_wreg, 5);
        chk("t1_wdata",  commit_wdata, 16'h1234);
        chk("t1_icnt1",  inst_count, 1);
        chk("t1_ccnt5",  cycle_count, 5);
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        mem_write = 0; mem_addr = 0; mem_data = 0;
        fetch(0, 0);
        chk("t1_pc2",    commit_pc, 16'h2);
        chk("t1_memwr",  commit_mem_write, 1);
        chk("t1_maddr",  commit_mem_addr, 16'h0040);
        chk("t1_mdata",  commit_mem_data, 16'hBEEF);
        chk("t1_regwr0", commit_reg_write, 0);
        fetch(0, 0);
        chk("t1_pc4",    commit_pc, 16'h4);
        chk("t1_memwr0", commit_mem_write, 0);
        fetch(0, 0);
        chk("t1_cv6",    commit_valid, 1);
        chk("t1_pc6",    commit_pc, 16'h6);
        chk("t1_icnt4",  inst_count, 4);
        chk("t1_ccnt8",  cycle_count, 8);
        fetch(0, 0);
        chk("t1_idle",   commit_valid, 0);
        chk("t1_hold",   commit_pc, 16'h6);

        // 2: two-cycle stall while 0x22 sits in X
        fetch(1, 16'h20); fetch(1, 16'h22); fetch(1, 16'h24);
        stall = 1;
        fetch(1, 16'h26);
        fetch(1, 16'h26);
        chk("t2_cvA",    commit_valid, 1);
        chk("t2_pcA",    commit_pc, 16'h20);
        stall = 0;
        fetch(1, 16'h26);
        chk("t2_bub1",   commit_valid, 0);
        fetch(0, 0);
        chk("t2_bub2",   commit_valid, 0);
        fetch(0, 0);
        chk("t2_cvB",    commit_valid, 1);
        chk("t2_pcB",    commit_pc, 16'h22);
        fetch(0, 0);
        chk("t2_pcC",    commit_pc, 16'h24);
        fetch(0, 0);
        chk("t2_pcD",    commit_pc, 16'h26);
        chk("t2_icnt",   inst_count, 8);
        fetch(0, 0);
        chk("t2_nodup",  commit_valid, 0);
        chk("t2_icnt2",  inst_count, 8);

        // 3: flush with branch in X; D and incoming fetch die
        fetch(1, 16'h30); fetch(1, 16'h32);
        flush = 1;
        fetch(1, 16'h34);
        flush = 0;
        fetch(1, 16'h40);
        fetch(0, 0);
        chk("t3_cvbr",   commit_valid, 1);
        chk("t3_pcbr",   commit_pc, 16'h30);
        fetch(0, 0);
        chk("t3_kill1",  commit_valid, 0);
        fetch(0, 0);
        chk("t3_kill2",  commit_valid, 0);
        fetch(0, 0);
        chk("t3_pctgt",  commit_pc, 16'h40);
        chk("t3_icnt",   inst_count, 10);
        fetch(0, 0);
        chk("t3_idle",   commit_valid, 0);

        // 4: flush and stall together -> flush wins
        fetch(1, 16'h50); fetch(1, 16'h52);
        flush = 1; stall = 1;
        fetch(1, 16'h54);
        flush = 0; stall = 0;
        fetch(0, 0);
        chk("t4_early",  commit_valid, 0);
        fetch(0, 0);
        chk("t4_cv",     commit_valid, 1);
        chk("t4_pc",     commit_pc, 16'h50);
        fetch(0, 0);
        chk("t4_kill1",  commit_valid, 0);
        fetch(0, 0);
        chk("t4_kill2",  commit_valid, 0);
        chk("t4_icnt",   inst_count, 11);

        // 6a: write enables on an empty W slot
        wb_reg_write = 1;
        fetch(0, 0);
        chk("t6_err_rw", commit_err, 1);
        chk("t6_err_cv", commit_valid, 0);
        wb_reg_write = 0;
        fetch(0, 0);
        chk("t6_err_off", commit_err, 0);
        mem_write = 1;
        fetch(0, 0);
        chk("t6_err_mw0", commit_err, 0);
        mem_write = 0;
        fetch(0, 0);
        chk("t6_err_mw1", commit_err, 1);
        fetch(0, 0);
        chk("t6_err_end", commit_err, 0);
        chk("t6_icnt",    inst_count, 11);

        // 5: HALT retires, then everything freezes
        fetch(1, 16'h000a); fetch(1, 16'h000c); fetch(1, 16'h000e);
        fetch(0, 0);
        wb_halt = 1;
        fetch(0, 0);
        chk("t5_cv",     commit_valid, 1);
        chk("t5_halt",   commit_halt, 1);
        chk("t5_pc",     commit_pc, 16'h000a);
        chk("t5_icnt",   inst_count, 12);
        chk("t5_ccnt",   cycle_count, cyc_model);
        halt_cyc = cyc_model;
        wb_halt = 0;
        fetch(1, 16'h70);
        chk("t5_nocv1",  commit_valid, 0);
        chk("t5_frz_i",  inst_count, 12);
        chk("t5_frz_c1", cycle_count, halt_cyc);
        chk("t5_sticky", commit_halt, 1);
        fetch(1, 16'h72);
        chk("t5_nocv2",  commit_valid, 0);
        chk("t5_frz_c2", cycle_count, halt_cyc);
        chk("t5_pchold", commit_pc, 16'h000a);

        // 6b: asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        $display("t=%0t async reset -> cv=%0d cpc=%h icnt=%0d ccnt=%0d halt=%0d",
                 $time, commit_valid, commit_pc, inst_count, cycle_count, commit_halt);
        chk("ar_halt",  commit_halt, 0);
        chk("ar_icnt",  inst_count, 0);
        chk("ar_ccnt",  cycle_count, 0);
        chk("ar_pc",    commit_pc, 0);
        chk("ar_inst",  commit_inst, 0);
        fd_valid = 0;
        tick();
        rst = 1'b1; cyc_model = 0;
        fetch(1, 16'h60); fetch(1, 16'h62); fetch(1, 16'h64);
        fetch(1, 16'h66);
        chk("ar_noearly", commit_valid, 0);
        fetch(0, 0);
        chk("ar_cv",    commit_valid, 1);
        chk("ar_pc60",  commit_pc, 16'h60);
        chk("ar_icnt1", inst_count, 1);
        chk("ar_ccnt5", cycle_count, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
